uart_rx: RTL and testbench

//  UART 8N1 receiver; the receive end of the serial link driven by the team's TX path.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_baud_counter.sv | 18 +
 rtl/uart_rx.sv | 61 ++++++
 tb/tb_uart_rx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encoding and default link parameters
package uart_pkg;
  localparam int CLKS_PER_BIT = 1302;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_baud_counter.sv
// rx_baud_counter: free-running bit-period counter with half and full bit ticks, restartable by clear
module rx_baud_counter #(
  parameter int CLKS_PER_BIT = 1302
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  logic [W-1:0] cnt;
  assign full_tick = cnt == W'(CLKS_PER_BIT - 1);
  assign half_tick = cnt == W'(HALF - 1);
  always_ff @(posedge clk)
    cnt <= (!reset || clear || full_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver that centre-samples a synchronised serial line and strobes good bytes or framing errors
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);
  import uart_pkg::*;
  localparam int IW = $clog2(DATA_BITS + 1);
  logic s1, rx_s, half_tick, full_tick, stop_tick;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  rx_state_t state, state_next;
  always_ff @(posedge clk)
    {s1, rx_s} <= !reset ? 2'b11 : {rx_in, s1};
  // restarting the counter on every state change aligns half/full ticks to the detected start edge
  rx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(state_next != state),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = rx_s ? IDLE : START;
      START: if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA:  if (full_tick && idx == IW'(DATA_BITS - 1)) state_next = STOP;
      STOP:  if (full_tick) state_next = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  assign stop_tick = state == STOP && full_tick;
  assign rx_busy = state != IDLE;
  // LSB arrives first, so shifting in from the top leaves bit i at position i after the last sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      idx          <= state != DATA ? '0 : full_tick ? idx + 1'b1 : idx;
      shreg        <= (state == DATA && full_tick) ? {rx_s, shreg[DATA_BITS-1:1]} : shreg;
      rx_data      <= (stop_tick && rx_s) ? shreg : rx_data;
      rx_valid     <= stop_tick && rx_s;
      rx_frame_err <= stop_tick && !rx_s;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames against uart_rx at a shortened bit time
module tb_uart_rx;
  localparam int CPB = 130;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_in = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_frame_err, rx_busy;
  logic [7:0] vq[$];
  logic prev_valid = 1'b0;
  int err_cnt = 0, vwide = 0, busy_late = 0;
  int n = 0, m = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) vq.push_back(rx_data);
    if (rx_frame_err) err_cnt++;
    if (rx_valid && prev_valid) vwide++;
    if (prev_valid && rx_busy) busy_late++;
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      m++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", rx_frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", rx_busy, 0);
    chk("idle_nvalid", vq.size(), 0);

    send_frame(8'hA5, 1'b1);
    chk("a5_count", vq.size(), 1);
    chk("a5_pulse", vq[0], 8'hA5);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_err", err_cnt, 0);
    chk("a5_width", vwide, 0);
    chk("a5_busy", busy_late, 0);
    repeat (CPB) @(negedge clk);

    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("gl_busy_rise", rx_busy, 1);
    repeat (20) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("gl_busy_hold", rx_busy, 1);
    repeat (30) @(negedge clk);
    chk("gl_busy_fall", rx_busy, 0);
    chk("gl_nvalid", vq.size(), 1);
    chk("gl_nerr", err_cnt, 0);
    repeat (CPB) @(negedge clk);

    send_frame(8'h3C, 1'b0);
    repeat (500) @(negedge clk);
    chk("brk_err", err_cnt, 1);
    chk("brk_busy", rx_busy, 1);
    chk("brk_data", rx_data, 8'hA5);
    chk("brk_nvalid", vq.size(), 1);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("brk_idle", rx_busy, 0);
    send_frame(8'h81, 1'b1);
    chk("x81_count", vq.size(), 2);
    chk("x81_data", rx_data, 8'h81);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    chk("b2b_count", vq.size(), 4);
    chk("b2b_first", vq[2], 8'h00);
    chk("b2b_second", vq[3], 8'hFF);
    repeat (CPB) @(negedge clk);

    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 1 || i == 3);
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_busy", rx_busy, 0);
    repeat (3 * CPB) @(negedge clk);
    chk("mid_nvalid", vq.size(), 4);
    chk("mid_nerr", err_cnt, 1);
    send_frame(8'h5A, 1'b1);
    chk("x5a_count", vq.size(), 5);
    chk("x5a_pulse", vq[4], 8'h5A);
    chk("x5a_data", rx_data, 8'h5A);
    chk("end_width", vwide, 0);
    chk("end_busy", busy_late, 0);
    chk("end_err", err_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, m);
    $finish;
  end
endmodule
